// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master sequencer.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_CLK_DIV    = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider, 0..DIV-1, strobing tick on the last count.
module spi_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: handshake in, CS/SCLK/MOSI sequencing, MISO capture,
// one-cycle rx_valid pulse on completion.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CLK_DIV    = SPI_CLK_DIV
) (
    input  logic                  spi_clk,
    input  logic                  spi_rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    if (DATA_WIDTH < 2 || CLK_DIV < 1) begin : g_bad_param
        $error("spi_master_ctrl: need DATA_WIDTH >= 2 and CLK_DIV >= 1");
    end

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  div_clr;
    logic                  tick;

    spi_clk_div #(
        .DIV(CLK_DIV)
    ) u_clk_div (
        .clk (spi_clk),
        .rst (spi_rst),
        .clr (div_clr),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        div_clr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_clr = 1'b1;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    state_d    = SETUP;
                    tx_shift_d = tx_data;
                    bit_cnt_d  = CNT_W'(DATA_WIDTH);
                    cs_n_d     = 1'b0;
                    mosi_d     = tx_data[DATA_WIDTH-1];
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    div_clr = 1'b1;
                end
            end
            SHIFT: begin
                // sclk low on tick means this tick is a rising edge
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], spi_miso};
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        mosi_d     = tx_shift_q[DATA_WIDTH-2];
                        bit_cnt_d  = bit_cnt_q - 1'b1;
                        if (bit_cnt_q == CNT_W'(1)) begin
                            state_d = HOLD;
                            div_clr = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d    = IDLE;
                    div_clr    = 1'b1;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge spi_clk or posedge spi_rst) begin
        if (spi_rst) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: vector table, random words against a
// slave model, abort-by-reset, and a CLK_DIV=1 instance.
module tb_spi_master_ctrl;

    localparam int W = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] tx_data = '0;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         busy;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;

    logic         tx_valid2 = 1'b0;
    logic         tx_ready2;
    logic [W-1:0] tx_data2 = '0;
    logic         rx_valid2;
    logic [W-1:0] rx_data2;
    logic         busy2;
    logic         sclk2;
    logic         cs_n2;
    logic         mosi2;

    spi_master_ctrl #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
        .spi_clk (clk),
        .spi_rst (rst),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .spi_sclk(sclk),
        .spi_cs_n(cs_n),
        .spi_mosi(mosi),
        .spi_miso(miso)
    );

    spi_master_ctrl #(.DATA_WIDTH(W), .CLK_DIV(1)) dut2 (
        .spi_clk (clk),
        .spi_rst (rst),
        .tx_valid(tx_valid2),
        .tx_ready(tx_ready2),
        .tx_data (tx_data2),
        .rx_valid(rx_valid2),
        .rx_data (rx_data2),
        .busy    (busy2),
        .spi_sclk(sclk2),
        .spi_cs_n(cs_n2),
        .spi_mosi(mosi2),
        .spi_miso(mosi2)
    );

    // Slave: presents word MSB first, advancing after each SCLK fall.
    logic [W-1:0] sl_word = '0;
    bit           loop_en = 1'b1;
    int           sl_idx = 0;

    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) sl_idx <= 0;
        else      sl_idx <= sl_idx + 1;
    end

    assign miso = loop_en ? mosi :
                  ((sl_idx < W) ? sl_word[W-1-sl_idx] : 1'b0);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input int div);
        return 1 + div * (2 * W + 2);
    endfunction

    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] slv,
                        input bit lp, input bit chain,
                        input logic [W-1:0] nxt, input int poke,
                        input logic [W-1:0] exp_rx);
        int lat, low, rises, waited;
        logic [W-1:0] mw;
        logic prev;
        sl_word  = slv;
        loop_en  = lp;
        tx_valid = 1'b1;
        tx_data  = tx;
        waited   = 0;
        while (!tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        if (chain) tx_data = nxt;
        else       tx_valid = 1'b0;
        lat = -1; low = 0; rises = 0; mw = '0; prev = sclk;
        for (int cyc = 1; cyc < 120; cyc++) begin
            if (cyc == 1) begin
                chk("cs_low_after_accept", {31'd0, cs_n}, 32'd0);
                chk("busy_after_accept", {31'd0, busy}, 32'd1);
                chk("not_ready_busy", {31'd0, tx_ready}, 32'd0);
            end
            if (poke != 0 && cyc == poke) begin
                tx_valid = 1'b1;
                tx_data  = 8'h11;
            end
            if (poke != 0 && cyc == poke + 1) tx_valid = 1'b0;
            if (!cs_n) low++;
            if (sclk && !prev) begin
                rises++;
                mw = {mw[W-2:0], mosi};
            end
            prev = sclk;
            if (rx_valid) begin
                lat = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("latency", lat, exp_lat(D));
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx});
        chk("mosi_bits", {24'd0, mw}, {24'd0, tx});
        chk("sclk_rises", rises, W);
        chk("cs_low_cycles", low, D * (2 * W + 2));
        chk("cs_high_done", {31'd0, cs_n}, 32'd1);
        chk("mosi_idle", {31'd0, mosi}, 32'd0);
        if (!chain) begin
            @(negedge clk);
            chk("rx_valid_pulse", {31'd0, rx_valid}, 32'd0);
            chk("ready_idle", {31'd0, tx_ready}, 32'd1);
        end
        if (poke != 0) begin
            int extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (!cs_n || busy) extra++;
            end
            chk("no_spurious_xfer", extra, 0);
        end
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] slv;
        bit           lp;
        bit           chain;
        int           poke;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{tx: 8'hA5, slv: 8'h00, lp: 1, chain: 0, poke: 0,  exp_rx: 8'hA5};
        tbl[1] = '{tx: 8'hFF, slv: 8'h3C, lp: 0, chain: 0, poke: 10, exp_rx: 8'h3C};
        tbl[2] = '{tx: 8'h01, slv: 8'h00, lp: 1, chain: 1, poke: 0,  exp_rx: 8'h01};
        tbl[3] = '{tx: 8'h80, slv: 8'h00, lp: 1, chain: 0, poke: 0,  exp_rx: 8'h80};

        // Reset asserted between edges must act immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            xfer(tbl[i].tx, tbl[i].slv, tbl[i].lp, tbl[i].chain,
                 (i < 3) ? tbl[i+1].tx : 8'h00, tbl[i].poke, tbl[i].exp_rx);
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] t, s;
            bit lp;
            t  = W'($urandom);
            s  = W'($urandom);
            lp = 1'($urandom_range(0, 1));
            xfer(t, s, lp, 1'b0, 8'h00, 0, lp ? t : s);
        end

        // Abort after the third SCLK rise.
        begin
            int n, rises, vis;
            logic prev;
            sl_word  = 8'hF0;
            loop_en  = 1'b0;
            tx_valid = 1'b1;
            tx_data  = 8'hE7;
            @(negedge clk);
            tx_valid = 1'b0;
            n = 0; rises = 0; prev = sclk;
            while (rises < 3 && n < 100) begin
                @(negedge clk);
                n++;
                if (sclk && !prev) rises++;
                prev = sclk;
            end
            chk("abort_third_rise", rises, 3);
            #2 rst = 1'b1;
            #1;
            chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
            chk("abort_sclk", {31'd0, sclk}, 32'd0);
            chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            vis = 0;
            repeat (60) begin
                @(negedge clk);
                if (rx_valid || !cs_n) vis++;
            end
            chk("abort_no_rx_valid", vis, 0);
        end
        xfer(8'h5A, 8'h00, 1'b1, 1'b0, 8'h00, 0, 8'h5A);

        // CLK_DIV=1 instance, loopback.
        begin
            int lat, rises, low, r1, r2;
            logic [W-1:0] mw;
            logic prev;
            chk("div1_ready", {31'd0, tx_ready2}, 32'd1);
            tx_valid2 = 1'b1;
            tx_data2  = 8'hC3;
            @(negedge clk);
            tx_valid2 = 1'b0;
            lat = -1; rises = 0; low = 0; r1 = 0; r2 = 0; mw = '0;
            prev = sclk2;
            for (int cyc = 1; cyc < 60; cyc++) begin
                if (!cs_n2) low++;
                if (sclk2 && !prev) begin
                    rises++;
                    if (rises == 1) r1 = cyc;
                    if (rises == 2) r2 = cyc;
                    mw = {mw[W-2:0], mosi2};
                end
                prev = sclk2;
                if (rx_valid2) begin
                    lat = cyc;
                    break;
                end
                @(negedge clk);
            end
            chk("div1_latency", lat, exp_lat(1));
            chk("div1_rx_data", {24'd0, rx_data2}, 32'h0000_00C3);
            chk("div1_mosi_bits", {24'd0, mw}, 32'h0000_00C3);
            chk("div1_rises", rises, W);
            chk("div1_sclk_period", r2 - r1, 2);
            chk("div1_cs_low", low, 2 * W + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
